// File: rtl/uart_txarb_pkg.sv
// uart_txarb shared definitions:
// state codes, uart command value and map offsets.
package uart_txarb_pkg;

  localparam logic [2:0] S_INIT  = 3'd0;
  localparam logic [2:0] S_IWAIT = 3'd1;
  localparam logic [2:0] S_IDLE  = 3'd2;
  localparam logic [2:0] S_ISSUE = 3'd3;
  localparam logic [2:0] S_WAIT  = 3'd4;
  localparam logic [2:0] S_DONE  = 3'd5;

  localparam int CMDDEVRDY = 0;

  // command registers sit 64 bits above the data word
  function automatic int cmd_off(
    input int archbitsz
  );
    return 64 / archbitsz;
  endfunction

  function automatic int addr_bits(
    input int archbitsz
  );
    return archbitsz - $clog2(archbitsz / 8);
  endfunction

  function automatic int ptr_bits(
    input int nreq
  );
    return (nreq > 1) ? $clog2(nreq) : 1;
  endfunction

endpackage

// File: rtl/uart_txarb_if.sv
// Wishbone segment between uart_txarb
// (master) and the uart slave port.
interface uart_txarb_if #(
  parameter int ARCHBITSZ = 16,
  parameter int ADDRBITSZ =
    ARCHBITSZ - $clog2(ARCHBITSZ / 8)
);

  logic                     cyc;
  logic                     stb;
  logic                     we;
  logic [ADDRBITSZ-1:0]     addr;
  logic [ARCHBITSZ/8-1:0]   sel;
  logic [ARCHBITSZ-1:0]     dat;
  logic                     bsy;
  logic                     ack;

  modport master (
    output cyc,
    output stb,
    output we,
    output addr,
    output sel,
    output dat,
    input  bsy,
    input  ack
  );

  modport slave (
    input  cyc,
    input  stb,
    input  we,
    input  addr,
    input  sel,
    input  dat,
    output bsy,
    output ack
  );

endinterface

// File: rtl/uart_txarb_rr.sv
// Round-robin picker: lowest requesting
// index at or above ptr, else lowest overall.
module uart_txarb_rr
  import uart_txarb_pkg::*;
#(
  parameter int NREQ = 2,
  parameter int PTRW = ptr_bits(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [PTRW-1:0] ptr,
  output logic [PTRW-1:0] idx,
  output logic            vld
);

  logic            hi_v;
  logic [PTRW-1:0] hi_i;
  logic            lo_v;
  logic [PTRW-1:0] lo_i;

  // descending scan so the lowest match wins
  always_comb begin
    hi_v = 1'b0;
    hi_i = '0;
    lo_v = 1'b0;
    lo_i = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (req[i]) begin
        lo_v = 1'b1;
        lo_i = PTRW'(i);
        if (PTRW'(i) >= ptr) begin
          hi_v = 1'b1;
          hi_i = PTRW'(i);
        end
      end
    end
  end

  assign vld = lo_v;
  assign idx = hi_v ? hi_i : lo_i;

endmodule

// File: rtl/uart_txarb.sv
// Shares one uart transmit path between
// NREQ byte producers over wishbone.
module uart_txarb
  import uart_txarb_pkg::*;
#(
  parameter int ARCHBITSZ = 16,
  parameter int NREQ      = 2,
  parameter int UARTADDR  = 0,
  parameter int TIMEOUT   = 1024
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [NREQ-1:0]   req_stb_i,
  input  logic [8*NREQ-1:0] req_dat_i,
  output logic [NREQ-1:0]   req_ack_o,
  output logic              err_o,
  output logic              rdy_o,
  uart_txarb_if.master      wb
);

  localparam int ADDRBITSZ = addr_bits(ARCHBITSZ);
  localparam int SELW      = ARCHBITSZ / 8;
  localparam int PTRW      = ptr_bits(NREQ);
  localparam int TMOW      = $clog2(TIMEOUT);

  localparam logic [ADDRBITSZ-1:0] DATA_ADDR =
    ADDRBITSZ'(UARTADDR);
  localparam logic [ADDRBITSZ-1:0] CMD_ADDR =
    ADDRBITSZ'(UARTADDR + cmd_off(ARCHBITSZ));
  localparam logic [ARCHBITSZ-1:0] CMD_WORD =
    ARCHBITSZ'(CMDDEVRDY);
  localparam logic [TMOW-1:0] TMO_LAST =
    TMOW'(TIMEOUT - 1);
  localparam logic [PTRW-1:0] PTR_LAST =
    PTRW'(NREQ - 1);

  logic [2:0]           state_q;
  logic                 cyc_q;
  logic                 stb_q;
  logic [ADDRBITSZ-1:0] addr_q;
  logic [ARCHBITSZ-1:0] dat_q;
  logic [PTRW-1:0]      rr_q;
  logic [PTRW-1:0]      grant_q;
  logic [TMOW-1:0]      tmo_q;

  logic [PTRW-1:0]      pick_idx;
  logic                 pick_vld;
  logic [7:0]           pick_byte;
  logic                 tmo_hit;

  uart_txarb_rr #(
    .NREQ (NREQ),
    .PTRW (PTRW)
  ) u_rr (
    .req (req_stb_i),
    .ptr (rr_q),
    .idx (pick_idx),
    .vld (pick_vld)
  );

  always_comb begin
    pick_byte = 8'h00;
    for (int i = 0; i < NREQ; i++) begin
      if (pick_idx == PTRW'(i)) begin
        pick_byte = req_dat_i[8*i +: 8];
      end
    end
  end

  assign tmo_hit = (tmo_q == TMO_LAST);

  assign wb.cyc  = cyc_q;
  assign wb.stb  = stb_q;
  assign wb.we   = stb_q;
  assign wb.addr = addr_q;
  assign wb.sel  = {SELW{stb_q}};
  assign wb.dat  = dat_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= S_INIT;
      cyc_q     <= 1'b0;
      stb_q     <= 1'b0;
      addr_q    <= '0;
      dat_q     <= '0;
      rr_q      <= '0;
      grant_q   <= '0;
      tmo_q     <= '0;
      req_ack_o <= '0;
      err_o     <= 1'b0;
      rdy_o     <= 1'b0;
    end else begin
      req_ack_o <= '0;
      err_o     <= 1'b0;
      unique case (state_q)
        S_INIT: begin
          // first cycle raises the strobe,
          // later cycles wait for acceptance
          if (!stb_q) begin
            cyc_q  <= 1'b1;
            stb_q  <= 1'b1;
            addr_q <= CMD_ADDR;
            dat_q  <= CMD_WORD;
          end else if (!wb.bsy) begin
            stb_q   <= 1'b0;
            tmo_q   <= '0;
            state_q <= S_IWAIT;
          end
        end
        S_IWAIT: begin
          if (wb.ack) begin
            cyc_q   <= 1'b0;
            rdy_o   <= 1'b1;
            state_q <= S_IDLE;
          end else if (tmo_hit) begin
            cyc_q   <= 1'b0;
            err_o   <= 1'b1;
            state_q <= S_INIT;
          end else begin
            tmo_q <= tmo_q + 1'b1;
          end
        end
        S_IDLE: begin
          if (pick_vld) begin
            grant_q <= pick_idx;
            cyc_q   <= 1'b1;
            stb_q   <= 1'b1;
            addr_q  <= DATA_ADDR;
            dat_q   <= ARCHBITSZ'(pick_byte);
            state_q <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (!wb.bsy) begin
            stb_q   <= 1'b0;
            tmo_q   <= '0;
            state_q <= S_WAIT;
          end
        end
        S_WAIT: begin
          // a timed-out byte is dropped but
          // its requester is still released
          if (wb.ack) begin
            cyc_q              <= 1'b0;
            req_ack_o[grant_q] <= 1'b1;
            state_q            <= S_DONE;
          end else if (tmo_hit) begin
            cyc_q              <= 1'b0;
            err_o              <= 1'b1;
            req_ack_o[grant_q] <= 1'b1;
            state_q            <= S_DONE;
          end else begin
            tmo_q <= tmo_q + 1'b1;
          end
        end
        S_DONE: begin
          rr_q    <= (grant_q == PTR_LAST) ?
                     '0 : grant_q + 1'b1;
          state_q <= S_IDLE;
        end
        default: begin
          cyc_q   <= 1'b0;
          stb_q   <= 1'b0;
          state_q <= S_INIT;
        end
      endcase
    end
  end

endmodule

// File: doc/uart_txarb.md
Name: uart_txarb

Overview:
- Wishbone master that shares one uart peripheral's transmit path between NREQ byte-stream requesters.
- After reset it issues the device-ready command once to the uart. It then grants requesters in round-robin order and performs one single-beat data write per granted byte.
- Sits between core-side debug/console producers and the uart slave port. Owns the master side of that bus segment.

Parameters:
- ARCHBITSZ, 16, bus data width; address width ADDRBITSZ = ARCHBITSZ - clog2(ARCHBITSZ/8).
- NREQ, 2, number of requesters, >= 1.
- UARTADDR, 0, uart base word address.
- TIMEOUT, 1024, max cycles from strobe acceptance to ack before abort; >= 4.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  synchronous active-high reset.
- req_stb_i  in  NREQ  bit n: requester n has a byte pending; held until its ack.
- req_dat_i  in  8*NREQ  byte n at [8n+7:8n]; stable while req_stb_i[n].
- req_ack_o  out  NREQ  one-cycle pulse: byte n consumed (sent or dropped).
- wb_cyc_o  out  1  bus cycle.
- wb_stb_o  out  1  strobe.
- wb_we_o  out  1  always 1 when wb_stb_o.
- wb_addr_o  out  ADDRBITSZ  word address.
- wb_sel_o  out  ARCHBITSZ/8  all ones.
- wb_dat_o  out  ARCHBITSZ  write data.
- wb_bsy_i  in  1  slave not accepting strobe.
- wb_ack_i  in  1  slave ack.
- err_o  out  1  one-cycle pulse on timeout abort.
- rdy_o  out  1  init done, arbiter live.

Behaviour:
- Reset (synchronous, active-high): state INIT; all outputs 0; rr pointer 0; timeout counter 0. Reset in any state aborts immediately: cyc/stb drop the next edge, and no req_ack is issued for the aborted byte.
- Addresses: data write to UARTADDR. Command write to UARTADDR + 64/ARCHBITSZ (command half of the map).
- Command value: CMDDEVRDY = 0, zero-extended to ARCHBITSZ.
- Data word: {zeros, byte}, byte in [7:0].
- States and transitions:
  - INIT: cyc=stb=1, addr=cmd address, dat=0; go to IWAIT when stb is accepted (stb & !bsy_i).
  - IWAIT: cyc=1, stb=0; go to IDLE on ack_i and set rdy_o=1.
  - IDLE: if any req_stb_i, grant the lowest index >= rr pointer (wrapping modulo NREQ) and latch its byte and index; go to ISSUE. Otherwise stay.
  - ISSUE: cyc=stb=1, addr=UARTADDR, dat=latched byte; go to WAIT when stb is accepted.
  - WAIT: cyc=1, stb=0; on ack_i go to DONE.
  - DONE: cyc=0; pulse req_ack_o[grant]; rr pointer = grant+1, wrapping to 0 at NREQ; go to IDLE.
- The byte is latched at grant. Changes on req_dat_i after grant are ignored.
- Back-to-back throughput: IDLE, ISSUE, WAIT, DONE, with WAIT lasting the slave's ack latency. Against the uart (ack 2 cycles after acceptance) that is 6 cycles per byte. Requests arriving during DONE are seen in the following IDLE.
- Strobe held while wb_bsy_i=1. The timeout counter does not run while waiting for acceptance.
- Timeout:
  - The counter resets at strobe acceptance and increments each cycle in IWAIT/WAIT.
  - Reaching TIMEOUT-1 with no ack aborts: cyc=0, err_o pulse.
  - In WAIT, go to DONE: the byte is dropped and the requester is still acked.
  - In IWAIT, return to INIT and retry.
- ack_i outside IWAIT/WAIT is ignored.
- A single requester asserting continuously is served every pass. Fairness: with all requesters asserting, grant order is 0,1,...,NREQ-1,0.
- rdy_o stays 1 until reset.

Decomposition:
- Shared package/include: CMDDEVRDY constant, uart command-offset computation (64/ARCHBITSZ), state encodings.
- One sub-module, uart_txarb_rr: NREQ-wide round-robin priority picker. Inputs: request vector and pointer. Outputs: grant index and valid. Purely combinational.
- Sequencing, latching and timeout stay in the top module.

Test Plan:
- Reset release, slave acks 2 cycles after acceptance -> first transaction is a write of 0 to UARTADDR+4 (ARCHBITSZ=16); rdy_o rises on the cycle after ack; no req_ack_o before rdy_o.
- req_stb_i=2'b01, byte 0x41 -> one write of 0x0041 to UARTADDR; req_ack_o=2'b01 pulses for exactly 1 cycle; total 6 cycles IDLE to next IDLE.
- Both requesters held asserted with bytes 0x61/0x62 for 4 bytes each -> write order 0x61,0x62,0x61,0x62,...; pointer alternates.
- wb_bsy_i high for 5 cycles during ISSUE -> stb and data held stable for 5 cycles; the single write is accepted once; no err_o.
- Slave never acks in WAIT, TIMEOUT=8 -> err_o pulses once; cyc drops; requester acked; next request proceeds normally.
- rst_i asserted during WAIT -> next edge: cyc=stb=0, no req_ack; after release the INIT command is reissued.
